seq_pattern_det: RTL and testbench
==================================

# seq_pattern_det

Parametrised, run-time programmable serial pattern detector with Moore-style registered output. It sits directly behind the switch/button input conditioning on the Basys3 datapath and consumes one qualified serial bit per enabled clock. It raises a one-cycle match flag when the last `PAT_W` accepted bits equal a loaded pattern. Overlapping and non-overlapping detection are selectable at run time, and an optional saturating match counter is provided.

## Interface
- `PAT_W`, 6, pattern length in bits; legal range 2..16.
- `PAT_RST`, 6'b110111 (width `PAT_W`), pattern register value after reset.
- `CNT_W`, 8, match counter width.
- `FILL_W`, $clog2(PAT_W+1), derived; not overridden.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `clr_n`  in  1  asynchronous active-low reset.
- `din_vld`  in  1  qualifies `din`; a bit is accepted only on edges where this is 1.
- `din`  in  1  serial data bit.
- `pat_ld`  in  1  load strobe for `pat_in`.
- `pat_in`  in  `PAT_W`  new pattern; MSB is the first bit of the sequence.
- `ovl_en`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `dout`  out  1  registered match pulse.
- `fill`  out  `FILL_W`  number of valid history bits, 0..`PAT_W` (observable state).
- `match_cnt`  out  `CNT_W`  saturating match count.

## Operation
- State: pattern register `pat`, history shift register `hist[PAT_W-1:0]` (newest bit at LSB), `fill` counter, `dout` flop, match counter.
- Reset (`clr_n`=0, asynchronous): `pat`=`PAT_RST`, `hist`=0, `fill`=0, `dout`=0, `match_cnt`=0.
- Priority per edge: reset > `pat_ld` > accepted bit > idle.
- `pat_ld`=1: `pat`<=`pat_in`; `fill`<=0; `dout`<=0; `match_cnt`<=0. `din` is ignored on that edge even when `din_vld`=1.
- Accepted bit (`din_vld`=1, `pat_ld`=0):
  - `hist`<={`hist`[PAT_W-2:0], `din`}.
  - Match condition: `fill`>=`PAT_W`-1 and {`hist`[PAT_W-2:0], `din`}==`pat`.
  - On a match, `dout`<=1 and `match_cnt` increments, holding at all-ones.
  - On a match with `ovl_en`=1, `fill` stays at `PAT_W`, so history is reused.
  - On a match with `ovl_en`=0, `fill`<=0, so the next match needs `PAT_W` fresh bits.
  - With no match, `fill`<=min(`fill`+1, `PAT_W`) and `dout`<=0.
- Idle edge (`din_vld`=0, `pat_ld`=0): `hist` and `fill` hold; `dout`<=0.
- `ovl_en` is sampled only on match edges and may change at any time.
- `fill` is the sole state encoding. Values above `PAT_W` are unreachable; if one is ever decoded, it forces `fill`<=0 on the next edge.

## Timing
- Latency: completing bit accepted at edge k gives `dout`=1 from k to k+1. `match_cnt` updates at the same edge.
- `dout` is always exactly one cycle wide per match. Back-to-back matches on consecutive accepted edges hold `dout` high continuously. This requires `ovl_en`=1 and a self-overlapping pattern such as all-ones.
- No combinational path from inputs to outputs.
- Reset mid-stream: all outputs go to reset values asynchronously. The first edge after `clr_n` rises behaves as the first accepted bit.
- `pat_ld` mid-stream: any partial match is discarded. The earliest possible new match is `PAT_W` accepted bits after the load edge.

## Configuration
- `SEQ_PATTERN_DET_MATCH_CNT_EN` defined: match counter built as described.
- Not defined: no counter flops; `match_cnt` is tied to 0 and the port list is unchanged.

## Test plan
- Reset: hold `clr_n`=0 with random `din`/`din_vld` -> `dout`=0, `fill`=0, `match_cnt`=0; after release, `PAT_RST` 110111 fed MSB-first -> `dout` pulses one cycle after the 6th bit.
- Overlap: PAT_W=4, load 1011, `ovl_en`=1, stream 1,0,1,1,0,1,1 -> `dout` high after bits 4 and 7; `match_cnt`=2.
- Non-overlap: same stream with `ovl_en`=0 -> `dout` high only after bit 4; `fill`=3 at end; `match_cnt`=1.
- Gaps: same 1011 stream with `din_vld`=0 for 3 cycles between every bit -> identical match positions in accepted-bit count; `dout` still one cycle wide; `fill` holds across gaps.
- Load collision: PAT_W=4, pattern 1111, `fill`=3, then `pat_ld`=1 with `pat_in`=0000 and `din_vld`=1,`din`=1 on the same edge -> no match, `fill`=0, `match_cnt`=0; four 0s -> `dout` pulse.
- Saturation (macro defined, CNT_W=2): pattern 11, `ovl_en`=1, ten consecutive 1s -> `dout` high continuously from bit 2; `match_cnt` stops at 3. Macro undefined -> `match_cnt` stays 0.

Source files
------------

// File: rtl/seq_pattern_det.sv
// Programmable serial pattern detector with a registered one-cycle match pulse.
// Define SEQ_PATTERN_DET_MATCH_CNT_EN to build the saturating match counter.
//
// fill value  | meaning
// 0..PAT_W-2  | collecting fresh history, no match possible on next bit
// PAT_W-1     | armed: the next accepted bit can complete a match
// PAT_W       | full window (steady state in overlapping mode)
// > PAT_W     | unreachable; recovers to 0 on the next edge
module seq_pattern_det #(
  parameter int               PAT_W   = 6,
  parameter logic [PAT_W-1:0] PAT_RST = 6'b110111,
  parameter int               CNT_W   = 8,
  parameter int               FILL_W  = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              din_vld,
  input  logic              din,
  input  logic              pat_ld,
  input  logic [PAT_W-1:0]  pat_in,
  input  logic              ovl_en,
  output logic              dout,
  output logic [FILL_W-1:0] fill,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  // Only PAT_W-1 history bits are kept: the oldest bit is shifted out before it can be compared.
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d, window;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              dout_q, dout_d;
  logic              fill_bad, hit;

  assign window   = {hist_q, din};
  assign fill_bad = (fill_q > FILL_FULL);
  assign hit      = din_vld && !pat_ld && !fill_bad &&
                    (fill_q >= FILL_ARM) && (window == pat_q);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
      dout_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      dout_q <= dout_d;
    end
  end

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    dout_d = 1'b0;
    if (pat_ld) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else begin
      if (din_vld) begin
        hist_d = window[PAT_W-2:0];
        if (hit) begin
          dout_d = 1'b1;
          fill_d = ovl_en ? FILL_FULL : '0;
        end else if (fill_q < FILL_FULL) begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
      if (fill_bad)
        fill_d = '0;
    end
  end

  assign dout = dout_q;
  assign fill = fill_q;

`ifdef SEQ_PATTERN_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      cnt_q <= '0;
    else if (pat_ld)
      cnt_q <= '0;
    else if (hit && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_det.sv
// Scoreboard bench for seq_pattern_det: a 6-bit default instance and a 4-bit/2-bit-counter instance.
module tb_seq_pattern_det;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  logic       vld0, din0, ld0, ovl0, dout0;
  logic [5:0] pin0;
  logic [2:0] fill0;
  logic [7:0] cnt0;
  logic       vld1, din1, ld1, ovl1, dout1;
  logic [3:0] pin1;
  logic [2:0] fill1;
  logic [1:0] cnt1;

  seq_pattern_det u6 (
    .clk(clk), .clr_n(clr_n), .din_vld(vld0), .din(din0), .pat_ld(ld0),
    .pat_in(pin0), .ovl_en(ovl0), .dout(dout0), .fill(fill0), .match_cnt(cnt0)
  );

  seq_pattern_det #(.PAT_W(4), .PAT_RST(4'b1001), .CNT_W(2)) u4 (
    .clk(clk), .clr_n(clr_n), .din_vld(vld1), .din(din1), .pat_ld(ld1),
    .pat_in(pin1), .ovl_en(ovl1), .dout(dout1), .fill(fill1), .match_cnt(cnt1)
  );

  typedef struct {
    int since;
    int win;
    int pat;
    int cnt;
    bit dout;
  } mdl_t;

  typedef struct {
    bit d0; int f0; int c0;
    bit d1; int f1; int c1;
  } exp_t;

  mdl_t m [2];
  exp_t sb [$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   pw [2]      = '{6, 4};
  int   rst_pat [2] = '{'h37, 'h9};
`ifdef SEQ_PATTERN_DET_MATCH_CNT_EN
  int   cmax [2] = '{255, 3};
  localparam bit CNT_ON = 1'b1;
`else
  int   cmax [2] = '{0, 0};
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference: count accepted bits since the last clear; a match needs PAT_W of them
  // and the last PAT_W accepted bits equal to the pattern.
  function automatic void mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].since = 0;
      m[i].win   = 0;
      m[i].pat   = rst_pat[i];
      m[i].cnt   = 0;
      m[i].dout  = 1'b0;
    end
  endfunction

  function automatic void mdl_edge(int i, bit v, bit d, bit l, int p, bit o);
    int mask = (1 << pw[i]) - 1;
    m[i].dout = 1'b0;
    if (l) begin
      m[i].pat   = p;
      m[i].since = 0;
      m[i].cnt   = 0;
    end else if (v) begin
      m[i].win = ((m[i].win * 2) + int'(d)) & mask;
      m[i].since++;
      if (m[i].since >= pw[i] && m[i].win == m[i].pat) begin
        m[i].dout = 1'b1;
        if (m[i].cnt < cmax[i]) m[i].cnt++;
        if (!o) m[i].since = 0;
      end
    end
  endfunction

  function automatic int fill_of(int i);
    return (m[i].since < pw[i]) ? m[i].since : pw[i];
  endfunction

  function automatic exp_t mk_exp();
    exp_t x;
    x.d0 = m[0].dout; x.f0 = fill_of(0); x.c0 = m[0].cnt;
    x.d1 = m[1].dout; x.f1 = fill_of(1); x.c1 = m[1].cnt;
    return x;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dout6", int'(dout0), int'(e.d0));
      chk("fill6", int'(fill0), e.f0);
      chk("cnt6",  int'(cnt0),  e.c0);
      chk("dout4", int'(dout1), int'(e.d1));
      chk("fill4", int'(fill1), e.f1);
      chk("cnt4",  int'(cnt1),  e.c1);
    end
  end

  task automatic tick();
    if (!clr_n) mdl_reset();
    @(posedge clk);
    if (clr_n) begin
      mdl_edge(0, vld0, din0, ld0, int'(pin0), ovl0);
      mdl_edge(1, vld1, din1, ld1, int'(pin1), ovl1);
    end
    sb.push_back(mk_exp());
    #1;
  endtask

  task automatic idle_all();
    vld0 = 1'b0; ld0 = 1'b0;
    vld1 = 1'b0; ld1 = 1'b0;
  endtask

  task automatic feed1(input bit d, input int gap);
    vld1 = 1'b1; din1 = d; ld1 = 1'b0;
    tick();
    vld1 = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic feed_stream(input logic [6:0] bits, input int gap);
    logic [6:0] b;
    b = bits;
    for (int k = 6; k >= 0; k--) feed1(b[k], gap);
  endtask

  task automatic load1(input logic [3:0] p, input bit o);
    ld1 = 1'b1; pin1 = p; ovl1 = o; vld1 = 1'b0;
    tick();
    ld1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [5:0] p6;
    clr_n = 1'b0;
    idle_all();
    din0 = 1'b0; din1 = 1'b0; pin0 = '0; pin1 = '0; ovl0 = 1'b1; ovl1 = 1'b1;
    mdl_reset();

    // Random activity while held in reset must be ignored.
    repeat (5) begin
      vld0 = 1'($urandom); din0 = 1'($urandom); vld1 = 1'($urandom); din1 = 1'($urandom);
      tick();
    end
    idle_all();
    clr_n = 1'b1;

    // Reset pattern 110111 fed MSB-first.
    p6 = 6'b110111;
    for (int k = 5; k >= 0; k--) begin
      vld0 = 1'b1; din0 = p6[k];
      tick();
    end
    chk("rst_pat_hit", int'(dout0), 1);
    vld0 = 1'b0;
    tick();
    chk("rst_pat_pulse_end", int'(dout0), 0);

    // Overlapping: 1011 found after bits 4 and 7.
    load1(4'b1011, 1'b1);
    feed_stream(7'b1011011, 0);
    chk("ovl_cnt", int'(cnt1), CNT_ON ? 2 : 0);

    // Non-overlapping: only the first occurrence counts.
    load1(4'b1011, 1'b0);
    feed_stream(7'b1011011, 0);
    chk("novl_fill", int'(fill1), 3);
    chk("novl_cnt", int'(cnt1), CNT_ON ? 1 : 0);

    // Gaps of three idle cycles between accepted bits.
    load1(4'b1011, 1'b1);
    feed_stream(7'b1011011, 3);
    chk("gap_cnt", int'(cnt1), CNT_ON ? 2 : 0);

    // Load on the same edge as an accepted bit that would have matched.
    load1(4'b1111, 1'b1);
    feed1(1'b1, 0); feed1(1'b1, 0); feed1(1'b1, 0);
    chk("coll_pre_fill", int'(fill1), 3);
    ld1 = 1'b1; pin1 = 4'b0000; vld1 = 1'b1; din1 = 1'b1;
    tick();
    ld1 = 1'b0; vld1 = 1'b0;
    chk("coll_dout", int'(dout1), 0);
    chk("coll_fill", int'(fill1), 0);
    chk("coll_cnt", int'(cnt1), 0);
    repeat (4) feed1(1'b0, 0);
    chk("coll_new_hit", int'(dout1), 1);

    // Saturation with a self-overlapping pattern.
    load1(4'b1111, 1'b1);
    repeat (10) begin
      vld1 = 1'b1; din1 = 1'b1;
      tick();
    end
    chk("sat_dout", int'(dout1), 1);
    chk("sat_cnt", int'(cnt1), CNT_ON ? 3 : 0);
    vld1 = 1'b0;

    // Asynchronous reset while dout is high.
    load1(4'b1011, 1'b1);
    feed_stream(7'b0001011, 0);
    @(negedge clk);
    #1;
    chk("pre_async_dout", int'(dout1), 1);
    clr_n = 1'b0;
    #1;
    chk("async_dout", int'(dout1), 0);
    chk("async_fill", int'(fill1), 0);
    chk("async_cnt", int'(cnt1), 0);
    tick();
    tick();
    clr_n = 1'b1;

    // Randomized traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      vld0 = ($urandom_range(0, 3) != 0);
      din0 = ($urandom_range(0, 3) != 0);
      ld0  = ($urandom_range(0, 60) == 0);
      pin0 = 6'($urandom);
      ovl0 = 1'($urandom);
      vld1 = ($urandom_range(0, 3) != 0);
      din1 = 1'($urandom);
      ld1  = ($urandom_range(0, 40) == 0);
      pin1 = 4'($urandom);
      ovl1 = 1'($urandom);
      tick();
    end
    idle_all();

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (sb.size() > 0) chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
